// File: rtl/gda_varlat_add_ctrl.sv
// Variable-latency sequencer around an external approximate adder: delivers the adder
// result when it matches the exact sum, otherwise one extra cycle for the exact sum.
// Optional statistics counters are built only when GDA_STATS_EN is defined.
module gda_varlat_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             approx_only,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH:0]   add_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_corrected,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_ops,
   output logic [CNT_W-1:0] stat_err
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and out data is stable meanwhile.
   typedef enum logic [1:0] {IDLE, EVAL, FIX, DONE} state_t;

   state_t           state;
   logic             approx_q;
   logic             mism_q;
   logic [WIDTH:0]   exact_sum;
   logic             match;

   assign exact_sum = {1'b0, add_a} + {1'b0, add_b};
   assign match     = (add_res == exact_sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         out_sum       <= '0;
         out_corrected <= 1'b0;
         add_a         <= '0;
         add_b         <= '0;
         approx_q      <= 1'b0;
         mism_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  add_a    <= in_a;
                  add_b    <= in_b;
                  approx_q <= approx_only;
                  in_ready <= 1'b0;
                  state    <= EVAL;
               end
            end
            EVAL: begin
               // mism_q records adder errors even when approx_only suppresses the fix
               mism_q <= ~match;
               if (match || approx_q) begin
                  out_sum       <= add_res;
                  out_corrected <= 1'b0;
                  out_valid     <= 1'b1;
                  state         <= DONE;
               end else begin
                  state <= FIX;
               end
            end
            FIX: begin
               out_sum       <= exact_sum;
               out_corrected <= 1'b1;
               out_valid     <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GDA_STATS_EN
   logic [CNT_W-1:0] ops_q;
   logic [CNT_W-1:0] err_q;
   logic             done_hs;

   assign done_hs = (state == DONE) && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_q <= '0;
         err_q <= '0;
      end else if (stat_clr) begin
         ops_q <= '0;
         err_q <= '0;
      end else if (done_hs) begin
         if (ops_q != '1) ops_q <= ops_q + 1'b1;
         if (mism_q && (err_q != '1)) err_q <= err_q + 1'b1;
      end
   end

   assign stat_ops = ops_q;
   assign stat_err = err_q;
`else
   logic unused_stats;
   assign unused_stats = stat_clr ^ mism_q;
   assign stat_ops     = '0;
   assign stat_err     = '0;
`endif

endmodule

// File: tb/tb_gda_varlat_add_ctrl.sv
// Bench for gda_varlat_add_ctrl with a bit-level model of the 5-bit-window approximate adder.
// Define GDA_STATS_EN for both files to exercise the statistics counters.
module tb_gda_varlat_add_ctrl;

   localparam int WIDTH = 8;
`ifdef GDA_STATS_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 16;
`endif
   localparam int WIN = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             approx_only = 1'b0;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH:0]   add_res;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH:0]   out_sum;
   logic             out_corrected;
   logic             stat_clr = 1'b0;
   logic [CNT_W-1:0] stat_ops;
   logic [CNT_W-1:0] stat_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // scoreboard entry: {latency[1:0], corrected, sum[8:0]}
   logic [11:0] exp_q[$];
   int          acc_q[$];
   logic        prev_valid = 1'b0;

   gda_varlat_add_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .approx_only(approx_only),
      .add_a(add_a), .add_b(add_b), .add_res(add_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_corrected(out_corrected), .stat_clr(stat_clr),
      .stat_ops(stat_ops), .stat_err(stat_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Carry into each bit is predicted from only the WIN bits below it.
   function automatic logic [WIDTH:0] approx_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      logic           c;
      s = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         c = 1'b0;
         for (int j = ((i - WIN) < 0 ? 0 : i - WIN); j < i; j++)
            c = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
         if (i < WIDTH) s[i] = a[i] ^ b[i] ^ c;
         else           s[i] = c;
      end
      return s;
   endfunction

   always_comb add_res = approx_add(add_a, add_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns #1 after the accept edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ap,
                       input logic [8:0] sum, input logic corr, input logic [1:0] lat);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
         return;
      end
      in_a = a; in_b = b; approx_only = ap; in_valid = 1'b1;
      @(posedge clk); #1;
      acc_q.push_back(cyc);
      exp_q.push_back({lat, corr, sum});
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("out_valid_timeout", out_valid, 1'b1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   // Latency counts rising edges from the accept edge (inclusive) to the edge raising out_valid.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out_valid: got out_sum 0x%0h with no operation pending", out_sum);
            end else begin
               check("latency", cyc - acc_q[0] + 1, {30'd0, exp_q[0][11:10]});
            end
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            void'(acc_q.pop_front());
            check("out_sum", {23'd0, out_sum}, {23'd0, e[8:0]});
            check("out_corrected", {31'd0, out_corrected}, {31'd0, e[9]});
         end
      end
      prev_valid = out_valid;
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_sum", out_sum, 9'h000);
      check("rst_out_corrected", out_corrected, 1'b0);
      check("rst_add_a", add_a, 8'h00);
      check("rst_add_b", add_b, 8'h00);
      check("rst_stat_ops", stat_ops, '0);

      send(8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 2'd2);
      send(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 2'd3);
      check("add_a_held", add_a, 8'h7F);
      send(8'h7F, 8'h01, 1'b1, 9'h040, 1'b0, 2'd2);
      send(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, 2'd2);
      wait_out_valid();
      @(posedge clk); #1;
`ifdef GDA_STATS_EN
      check("stat_ops_4", stat_ops, 4'd4);
      check("stat_err_2", stat_err, 4'd2);
`else
      check("stat_ops_off", stat_ops, '0);
      check("stat_err_off", stat_err, '0);
`endif

      // reset while the operation sits in EVAL: dropped silently
      send(8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 2'd2);
      rst = 1'b1;
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_sum", out_sum, 9'h000);
      check("midrst_stat_ops", stat_ops, '0);
      @(posedge clk); #1 rst = 1'b0;

      // backpressure: result held, second request ignored
      out_ready = 1'b0;
      send(8'h05, 8'h03, 1'b0, 9'h008, 1'b0, 2'd2);
      wait_out_valid();
      in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_out_sum", out_sum, 9'h008);
         check("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_add_a_kept", add_a, 8'h05);
      check("bp_out_valid_low", out_valid, 1'b0);

`ifdef GDA_STATS_EN
      check("stat_ops_1", stat_ops, 4'd1);
      for (int i = 0; i < 16; i++) send(8'h01, 8'h01, 1'b0, 9'h002, 1'b0, 2'd2);
      wait_out_valid();
      @(posedge clk); #1;
      check("stat_ops_sat", stat_ops, 4'hF);
      check("stat_err_0", stat_err, 4'd0);
      out_ready = 1'b0;
      send(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 2'd3);
      wait_out_valid();
      out_ready = 1'b1; stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      check("clr_stat_ops", stat_ops, 4'd0);
      check("clr_stat_err", stat_err, 4'd0);
`else
      stat_clr = 1'b1;
      send(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 2'd3);
      stat_clr = 1'b0;
      wait_out_valid();
      @(posedge clk); #1;
      check("stat_ops_off2", stat_ops, '0);
      check("stat_err_off2", stat_err, '0);
`endif

      // drain scoreboard
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check("drain_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
